// File: rtl/password_pkg.sv
// Package: password_pkg
// Shared definitions for the password lock sequencer.
//  - state_t : FSM state codes as seen on state_o
//  - DIGIT_W : width of one BCD digit
//  - BLANK   : nibble the HEX decoders render as an unlit digit
//  - digit_valid() : true for BCD digits 0..9
package password_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    FAIL    = 3'd3,
    OPEN    = 3'd4,
    LOCKOUT = 3'd5,
    CHANGE  = 3'd6
  } state_t;

  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/password_entry_ctrl_sec_tick_gen.sv
// Module: sec_tick_gen
// Emits a 1-cycle tick once every CLK_HZ cycles. A synchronous restart
// zeroes the counter so the next tick arrives a full period later.
// Ports:
//  clk        in  system clock
//  rst_a_n    in  asynchronous reset, active-low
//  restart_i  in  synchronous counter restart
//  tick_o     out 1-cycle pulse per period
module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running period counter; wraps at LAST or on restart.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      cnt_q <= '0;
    end else if (restart_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/password_entry_ctrl.sv
// Module: password_entry_ctrl
// Sequencer for the password lock: captures BCD digits on enter strobes,
// checks the code, counts retries, runs the timed lockout and drives the
// status/digit buses for the HEX display logic. All outputs are registered.
// Optional feature: define PASSWORD_CHANGE_EN to allow a new code to be
// entered from OPEN (state CHANGE). Without it the code is DEFAULT_CODE.
// Ports:
//  clk, rst_a_n  clock, asynchronous active-low reset
//  digit_i       BCD digit from switches
//  enter_i       1-cycle digit strobe
//  clear_i       1-cycle abort / relock strobe
//  state_o       current state (password_pkg::state_t code)
//  entered_o     digits entered so far, newest in the low nibble
//  n_entered_o   number of digits entered
//  unlock_o      high while unlocked
//  locked_o      high while in LOCKOUT
//  tries_left_o  remaining attempts
//  lock_secs_o   seconds left in lockout, 0 otherwise
module password_entry_ctrl import password_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int N_DIGITS = 4,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_SEC = 10,
  parameter logic [N_DIGITS*4-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                  clk,
  input  logic                  rst_a_n,
  input  logic [3:0]            digit_i,
  input  logic                  enter_i,
  input  logic                  clear_i,
  output logic [2:0]            state_o,
  output logic [N_DIGITS*4-1:0] entered_o,
  output logic [2:0]            n_entered_o,
  output logic                  unlock_o,
  output logic                  locked_o,
  output logic [2:0]            tries_left_o,
  output logic [7:0]            lock_secs_o
);

  localparam int CW = N_DIGITS * DIGIT_W;
  localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);
  localparam logic [7:0] SECS_INIT = 8'(LOCK_SEC);
  localparam logic [2:0] N_FULL = 3'(N_DIGITS);

  state_t        state_q, state_d;
  logic [CW-1:0] entered_q, entered_d;
  logic [2:0]    n_q, n_d;
  logic          unlock_q, unlock_d;
  logic          locked_q, locked_d;
  logic [2:0]    tries_q, tries_d;
  logic [7:0]    secs_q, secs_d;
  logic [CW-1:0] stored_code;
  logic [CW-1:0] shifted;
  logic          digit_ok;
  logic          restart;
  logic          tick;

`ifdef PASSWORD_CHANGE_EN
  logic [CW-1:0] stored_d;

  // The stored code is writable from CHANGE and reverts to default on reset.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      stored_code <= DEFAULT_CODE;
    end else begin
      stored_code <= stored_d;
    end
  end
`else
  assign stored_code = DEFAULT_CODE;
`endif

  assign digit_ok = digit_valid(digit_i);
  assign shifted  = {entered_q[CW-DIGIT_W-1:0], digit_i};

  // Restart the second counter on the transition into a timed state so
  // the first second there is full length.
  assign restart = (state_d != state_q) && (state_d == FAIL || state_d == LOCKOUT);

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk       (clk),
    .rst_a_n   (rst_a_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q   <= IDLE;
      entered_q <= '0;
      n_q       <= '0;
      unlock_q  <= 1'b0;
      locked_q  <= 1'b0;
      tries_q   <= TRIES_INIT;
      secs_q    <= '0;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      n_q       <= n_d;
      unlock_q  <= unlock_d;
      locked_q  <= locked_d;
      tries_q   <= tries_d;
      secs_q    <= secs_d;
    end
  end

  // Next-state logic. clear_i is tested before enter_i wherever it is honoured.
  always_comb begin
    state_d   = state_q;
    entered_d = entered_q;
    n_d       = n_q;
    tries_d   = tries_q;
    secs_d    = secs_q;
`ifdef PASSWORD_CHANGE_EN
    stored_d  = stored_code;
`endif
    case (state_q)
      IDLE, ENTRY: begin
        if (clear_i) begin
          state_d   = IDLE;
          entered_d = '0;
          n_d       = '0;
        end else if (enter_i && digit_ok) begin
          entered_d = shifted;
          n_d       = n_q + 3'd1;
          state_d   = (n_q + 3'd1 == N_FULL) ? CHECK : ENTRY;
        end
      end
      CHECK: begin
        if (entered_q == stored_code) begin
          state_d = OPEN;
          tries_d = TRIES_INIT;
        end else if (tries_q <= 3'd1) begin
          state_d = LOCKOUT;
          tries_d = '0;
          secs_d  = SECS_INIT;
        end else begin
          state_d = FAIL;
          tries_d = tries_q - 3'd1;
        end
      end
      FAIL: begin
        if (tick) begin
          state_d   = IDLE;
          entered_d = '0;
          n_d       = '0;
        end
      end
      OPEN: begin
        if (clear_i) begin
          state_d   = IDLE;
          entered_d = '0;
          n_d       = '0;
        end
`ifdef PASSWORD_CHANGE_EN
        else if (enter_i && digit_ok) begin
          state_d   = CHANGE;
          entered_d = {{(CW-DIGIT_W){1'b0}}, digit_i};
          n_d       = 3'd1;
        end
`endif
      end
`ifdef PASSWORD_CHANGE_EN
      CHANGE: begin
        if (clear_i) begin
          state_d   = IDLE;
          entered_d = '0;
          n_d       = '0;
        end else if (enter_i && digit_ok) begin
          if (n_q + 3'd1 == N_FULL) begin
            stored_d  = shifted;
            state_d   = IDLE;
            entered_d = '0;
            n_d       = '0;
          end else begin
            entered_d = shifted;
            n_d       = n_q + 3'd1;
          end
        end
      end
`endif
      LOCKOUT: begin
        if (tick) begin
          if (secs_q <= 8'd1) begin
            state_d   = IDLE;
            secs_d    = '0;
            tries_d   = TRIES_INIT;
            entered_d = '0;
            n_d       = '0;
          end else begin
            secs_d = secs_q - 8'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        entered_d = '0;
        n_d       = '0;
      end
    endcase
    unlock_d = (state_d == OPEN) || (state_d == CHANGE);
    locked_d = (state_d == LOCKOUT);
  end

  assign state_o      = state_q;
  assign entered_o    = entered_q;
  assign n_entered_o  = n_q;
  assign unlock_o     = unlock_q;
  assign locked_o     = locked_q;
  assign tries_left_o = tries_q;
  assign lock_secs_o  = secs_q;

endmodule

// File: tb/tb_password_entry_ctrl.sv
// Testbench: tb_password_entry_ctrl
// Directed, self-checking bench for password_entry_ctrl with CLK_HZ=10
// (one "second" = 10 cycles). A vector table covers entry and the
// single-cycle edge cases; hand-written sequences cover retries, lockout,
// reset during lockout and (with PASSWORD_CHANGE_EN) the code change.
module tb_password_entry_ctrl;
  import password_pkg::*;

  logic        clk;
  logic        rst_a_n;
  logic [3:0]  digit_i;
  logic        enter_i;
  logic        clear_i;
  logic [2:0]  state_o;
  logic [15:0] entered_o;
  logic [2:0]  n_entered_o;
  logic        unlock_o;
  logic        locked_o;
  logic [2:0]  tries_left_o;
  logic [7:0]  lock_secs_o;

  int errors = 0;
  int checks = 0;

  password_entry_ctrl #(
    .CLK_HZ(10), .N_DIGITS(4), .MAX_TRIES(3), .LOCK_SEC(10), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk          (clk),
    .rst_a_n      (rst_a_n),
    .digit_i      (digit_i),
    .enter_i      (enter_i),
    .clear_i      (clear_i),
    .state_o      (state_o),
    .entered_o    (entered_o),
    .n_entered_o  (n_entered_o),
    .unlock_o     (unlock_o),
    .locked_o     (locked_o),
    .tries_left_o (tries_left_o),
    .lock_secs_o  (lock_secs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        enter;
    logic        clear;
    logic [3:0]  digit;
    state_t      st;
    logic [15:0] ent;
    int          n;
    logic        unlock;
    int          tries;
  } vec_t;

  vec_t vecs[13];

  // Drive one cycle of inputs from the falling edge, then sample 1 unit after the rising edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic [3:0] d);
    @(negedge clk);
    enter_i = en;
    clear_i = clr;
    digit_i = d;
    @(posedge clk);
    #1;
    enter_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0);
  endtask

  task automatic enterCode(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, 1'b0, code[i*4 +: 4]);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " state"}, int'(state_o), int'(IDLE));
    checkOutput({tag, " entered"}, int'(entered_o), 0);
    checkOutput({tag, " n_entered"}, int'(n_entered_o), 0);
    checkOutput({tag, " unlock"}, int'(unlock_o), 0);
    checkOutput({tag, " locked"}, int'(locked_o), 0);
    checkOutput({tag, " tries"}, int'(tries_left_o), 3);
    checkOutput({tag, " secs"}, int'(lock_secs_o), 0);
  endtask

  initial begin
    rst_a_n = 1'b0;
    enter_i = 1'b0;
    clear_i = 1'b0;
    digit_i = 4'd0;

    // enter, clear, digit, state, entered, n, unlock, tries
    vecs[0]  = '{1'b1, 1'b0, 4'h1, ENTRY, 16'h0001, 1, 1'b0, 3};
    vecs[1]  = '{1'b1, 1'b0, 4'hA, ENTRY, 16'h0001, 1, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 4'h2, ENTRY, 16'h0012, 2, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b0, 4'h7, ENTRY, 16'h0012, 2, 1'b0, 3};
    vecs[4]  = '{1'b1, 1'b1, 4'h3, IDLE,  16'h0000, 0, 1'b0, 3};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, IDLE,  16'h0000, 0, 1'b0, 3};
    vecs[6]  = '{1'b1, 1'b0, 4'h1, ENTRY, 16'h0001, 1, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 4'h2, ENTRY, 16'h0012, 2, 1'b0, 3};
    vecs[8]  = '{1'b1, 1'b0, 4'h3, ENTRY, 16'h0123, 3, 1'b0, 3};
    vecs[9]  = '{1'b1, 1'b0, 4'h4, CHECK, 16'h1234, 4, 1'b0, 3};
    vecs[10] = '{1'b0, 1'b0, 4'h0, OPEN,  16'h1234, 4, 1'b1, 3};
    vecs[11] = '{1'b0, 1'b1, 4'h0, IDLE,  16'h0000, 0, 1'b0, 3};
    vecs[12] = '{1'b1, 1'b0, 4'hF, IDLE,  16'h0000, 0, 1'b0, 3};

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_a_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].enter, vecs[i].clear, vecs[i].digit);
      checkOutput($sformatf("vec%0d state", i), int'(state_o), int'(vecs[i].st));
      checkOutput($sformatf("vec%0d entered", i), int'(entered_o), int'(vecs[i].ent));
      checkOutput($sformatf("vec%0d n_entered", i), int'(n_entered_o), vecs[i].n);
      checkOutput($sformatf("vec%0d unlock", i), int'(unlock_o), int'(vecs[i].unlock));
      checkOutput($sformatf("vec%0d tries", i), int'(tries_left_o), vecs[i].tries);
      checkOutput($sformatf("vec%0d locked", i), int'(locked_o), 0);
    end

`ifndef PASSWORD_CHANGE_EN
    // Without the change feature, enter in OPEN is ignored.
    enterCode(16'h1234);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h5);
    checkOutput("open enter state", int'(state_o), int'(OPEN));
    checkOutput("open enter entered", int'(entered_o), 16'h1234);
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("open clear state", int'(state_o), int'(IDLE));
`endif

    // Two wrong codes: FAIL for 10 cycles each, tries 2 then 1.
    for (int k = 0; k < 2; k++) begin
      enterCode(16'h1111);
      checkOutput($sformatf("wrong%0d check", k), int'(state_o), int'(CHECK));
      idleCycles(1);
      checkOutput($sformatf("wrong%0d fail", k), int'(state_o), int'(FAIL));
      checkOutput($sformatf("wrong%0d tries", k), int'(tries_left_o), 2 - k);
      idleCycles(9);
      checkOutput($sformatf("wrong%0d hold", k), int'(state_o), int'(FAIL));
      idleCycles(1);
      checkOutput($sformatf("wrong%0d idle", k), int'(state_o), int'(IDLE));
      checkOutput($sformatf("wrong%0d entered", k), int'(entered_o), 0);
      checkOutput($sformatf("wrong%0d n", k), int'(n_entered_o), 0);
    end

    // Third wrong code: lockout, inputs ignored, countdown each 10 cycles.
    enterCode(16'h1111);
    idleCycles(1);
    checkOutput("lock state", int'(state_o), int'(LOCKOUT));
    checkOutput("lock locked", int'(locked_o), 1);
    checkOutput("lock secs", int'(lock_secs_o), 10);
    checkOutput("lock tries", int'(tries_left_o), 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 4'h1);
    applyStimulus(1'b1, 1'b1, 4'h2);
    checkOutput("lock ignore state", int'(state_o), int'(LOCKOUT));
    checkOutput("lock secs 9 cyc", int'(lock_secs_o), 10);
    idleCycles(1);
    checkOutput("lock secs 10 cyc", int'(lock_secs_o), 9);
    idleCycles(89);
    checkOutput("lock secs 99 cyc", int'(lock_secs_o), 1);
    checkOutput("lock still", int'(state_o), int'(LOCKOUT));
    idleCycles(1);
    checkOutput("unlock state", int'(state_o), int'(IDLE));
    checkOutput("unlock tries", int'(tries_left_o), 3);
    checkOutput("unlock locked", int'(locked_o), 0);
    checkOutput("unlock secs", int'(lock_secs_o), 0);

    // Reach lockout again and reset with 5 seconds remaining.
    for (int k = 0; k < 2; k++) begin
      enterCode(16'h4321);
      idleCycles(11);
    end
    enterCode(16'h4321);
    idleCycles(1);
    checkOutput("relock state", int'(state_o), int'(LOCKOUT));
    idleCycles(50);
    checkOutput("relock secs 5", int'(lock_secs_o), 5);
    @(negedge clk);
    rst_a_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst_a_n = 1'b1;
    enterCode(16'h1234);
    idleCycles(1);
    checkOutput("post reset open", int'(state_o), int'(OPEN));
    applyStimulus(1'b0, 1'b1, 4'h0);

`ifdef PASSWORD_CHANGE_EN
    // Change the code to 9876 from OPEN, then verify old fails and new opens.
    enterCode(16'h1234);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h9);
    checkOutput("chg state", int'(state_o), int'(CHANGE));
    checkOutput("chg entered", int'(entered_o), 16'h0009);
    checkOutput("chg unlock", int'(unlock_o), 1);
    applyStimulus(1'b1, 1'b0, 4'h8);
    applyStimulus(1'b1, 1'b0, 4'h7);
    checkOutput("chg entered3", int'(entered_o), 16'h0987);
    applyStimulus(1'b1, 1'b0, 4'h6);
    checkOutput("chg done state", int'(state_o), int'(IDLE));
    checkOutput("chg done unlock", int'(unlock_o), 0);
    enterCode(16'h1234);
    idleCycles(1);
    checkOutput("old code fail", int'(state_o), int'(FAIL));
    idleCycles(10);
    enterCode(16'h9876);
    idleCycles(1);
    checkOutput("new code open", int'(state_o), int'(OPEN));
    checkOutput("new code tries", int'(tries_left_o), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
